// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle
// Purpose: groups the pipeline-side hazard inputs and the controller outputs.
// Modports:
//   master - pipeline side.
//            Drives if_id_rs/rt, id_ex_rt, id_ex_mem_read, branch_taken and mem_busy.
//            Receives the enables, the flushes, state and the perf counters.
//   slave  - hazard controller side (the reverse directions).
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic [4:0]       id_ex_rt;
  logic             id_ex_mem_read;
  logic             branch_taken;
  logic             mem_busy;
  logic             pc_write;
  logic             if_id_write;
  logic             ex_mem_write;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output if_id_rs, if_id_rt, id_ex_rt, id_ex_mem_read, branch_taken, mem_busy,
    input  pc_write, if_id_write, ex_mem_write, if_id_flush, id_ex_flush,
    input  state, stall_count, flush_count
  );

  modport slave (
    input  if_id_rs, if_id_rt, id_ex_rt, id_ex_mem_read, branch_taken, mem_busy,
    output pc_write, if_id_write, ex_mem_write, if_id_flush, id_ex_flush,
    output state, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Purpose: resolves data-memory freezes, taken-branch redirects and load-use hazards.
//          The priority is mem_busy > branch > load-use.
//          It drives the pipeline register enables and the bubble controls.
// Ports:
//   clock   - single clock; all state changes on posedge.
//   reset_n - asynchronous active-low reset.
//             While low: enables are 0 and both flushes are 1.
//   hz      - slave modport of pipeline_hazard_ctrl_if (hazard inputs, enables, flushes, state, counters).
// Parameters:
//   FLUSH_CYCLES - IF/ID flush cycles after a taken branch (1..7).
//   CNT_W        - width of the performance counters.
// Optional feature macro: PERF_CNT_EN.
//   Builds the saturating stall_count and flush_count counters.
//   Without it, both counters are tied to 0.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_e;

  localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d, mode;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       pc_w, ifid_w, exmem_w, ifid_fl, idex_fl;
  logic       load_use, branch_ev, legal_st;

  assign load_use  = hz.id_ex_mem_read && (hz.id_ex_rt != 5'd0) &&
                     ((hz.id_ex_rt == hz.if_id_rs) || (hz.id_ex_rt == hz.if_id_rt));
  assign branch_ev = hz.branch_taken || pend_q;
  assign legal_st  = (state_q == RUN) || (state_q == MEM_WAIT) || (state_q == FLUSH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    exmem_w = 1'b1;
    ifid_fl = 1'b0;
    idex_fl = 1'b0;
    // The release cycle of MEM_WAIT behaves like the state that was frozen.
    // A non-zero cnt means a flush sequence was interrupted.
    mode = state_q;
    if (state_q == MEM_WAIT) mode = (cnt_q != 3'd0) ? FLUSH : RUN;

    if (hz.mem_busy && legal_st) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      exmem_w = 1'b0;
      state_d = MEM_WAIT;
      // A branch during a freeze is remembered until the memory is released.
      if (hz.branch_taken) pend_d = 1'b1;
    end else begin
      case (mode)
        RUN: begin
          state_d = RUN;
          if (branch_ev) begin
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
            pend_d  = 1'b0;
            if (RELOAD != 3'd0) begin
              state_d = FLUSH;
              cnt_d   = RELOAD;
            end
          end else if (load_use) begin
            pc_w    = 1'b0;
            ifid_w  = 1'b0;
            idex_fl = 1'b1;
          end
        end
        FLUSH: begin
          ifid_fl = 1'b1;
          if (branch_ev) begin
            idex_fl = 1'b1;
            pend_d  = 1'b0;
            cnt_d   = RELOAD;
            state_d = (RELOAD == 3'd0) ? RUN : FLUSH;
          end else if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = RUN;
          end else begin
            cnt_d   = cnt_q - 3'd1;
            state_d = FLUSH;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = 3'd0;
          pend_d  = 1'b0;
        end
      endcase
    end

    if (!reset_n) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      exmem_w = 1'b0;
      ifid_fl = 1'b1;
      idex_fl = 1'b1;
    end
  end

  assign hz.pc_write     = pc_w;
  assign hz.if_id_write  = ifid_w;
  assign hz.ex_mem_write = exmem_w;
  assign hz.if_id_flush  = ifid_fl;
  assign hz.id_ex_flush  = idex_fl;
  assign hz.state        = state_q;

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_w && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + ONE;
      if (ifid_fl && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + ONE;
    end
  end

  assign hz.stall_count = stall_q;
  assign hz.flush_count = flush_q;
`else
  assign hz.stall_count = {CNT_W{1'b0}};
  assign hz.flush_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  localparam int FC = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .hz      (hz.slave)
  );

  int n_pass = 0;
  int n_chk  = 0;

  // Reference model state: memory wait flag, owed flush cycles, pending branch, perf counts.
  bit m_wait;
  bit m_pend;
  int m_left;
  int m_stall;
  int m_flush;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_counters(input string tag);
`ifdef PERF_CNT_EN
    check({tag, ".stall_count"}, 32'(hz.stall_count), 32'(m_stall));
    check({tag, ".flush_count"}, 32'(hz.flush_count), 32'(m_flush));
`else
    check({tag, ".stall_count"}, 32'(hz.stall_count), 32'd0);
    check({tag, ".flush_count"}, 32'(hz.flush_count), 32'd0);
`endif
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #2;
    m_wait  = 0;
    m_pend  = 0;
    m_left  = 0;
    m_stall = 0;
    m_flush = 0;
    check({tag, ".pc_write"},     32'(hz.pc_write), 32'd0);
    check({tag, ".if_id_write"},  32'(hz.if_id_write), 32'd0);
    check({tag, ".ex_mem_write"}, 32'(hz.ex_mem_write), 32'd0);
    check({tag, ".if_id_flush"},  32'(hz.if_id_flush), 32'd1);
    check({tag, ".id_ex_flush"},  32'(hz.id_ex_flush), 32'd1);
    check({tag, ".state"},        32'(hz.state), 32'd0);
    check_counters(tag);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic step(input string tag, input int rs, input int rt, input int ex_rt,
                      input bit mr, input bit br, input bit mb);
    logic e_pc, e_ifw, e_exw, e_iff, e_idf;
    int   e_state;
    bit   lu;
    hz.if_id_rs       = 5'(rs);
    hz.if_id_rt       = 5'(rt);
    hz.id_ex_rt       = 5'(ex_rt);
    hz.id_ex_mem_read = mr;
    hz.branch_taken   = br;
    hz.mem_busy       = mb;
    #2;
    e_state = m_wait ? 1 : ((m_left > 0) ? 2 : 0);
    lu = mr && (ex_rt != 0) && ((ex_rt == rs) || (ex_rt == rt));
    {e_pc, e_ifw, e_exw, e_iff, e_idf} = 5'b11100;
    if (mb) begin
      {e_pc, e_ifw, e_exw, e_iff, e_idf} = 5'b00000;
      if (br) m_pend = 1;
      m_wait = 1;
    end else begin
      m_wait = 0;
      if (br || m_pend) begin
        e_iff  = 1;
        e_idf  = 1;
        m_pend = 0;
        m_left = FC - 1;
      end else if (m_left > 0) begin
        e_iff = 1;
        m_left--;
      end else if (lu) begin
        e_pc  = 0;
        e_ifw = 0;
        e_idf = 1;
      end
    end
    check({tag, ".state"},        32'(hz.state), 32'(e_state));
    check({tag, ".pc_write"},     32'(hz.pc_write), 32'(e_pc));
    check({tag, ".if_id_write"},  32'(hz.if_id_write), 32'(e_ifw));
    check({tag, ".ex_mem_write"}, 32'(hz.ex_mem_write), 32'(e_exw));
    check({tag, ".if_id_flush"},  32'(hz.if_id_flush), 32'(e_iff));
    check({tag, ".id_ex_flush"},  32'(hz.id_ex_flush), 32'(e_idf));
    check_counters(tag);
    if (!e_pc && m_stall < CMAX) m_stall++;
    if (e_iff && m_flush < CMAX) m_flush++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1, 2, 3, 0, 0, 0);
  endtask

  initial begin
    hz.if_id_rs       = 5'd0;
    hz.if_id_rt       = 5'd0;
    hz.id_ex_rt       = 5'd0;
    hz.id_ex_mem_read = 1'b0;
    hz.branch_taken   = 1'b0;
    hz.mem_busy       = 1'b0;
    #1;
    do_reset("rst0");
    idle("idle0", 2);

    // Load-use: hit on rs, bubble clears it, rt=0 never hits, hit on rt.
    step("lu_rs", 5, 0, 5, 1, 0, 0);
    step("lu_bubble", 5, 0, 0, 0, 0, 0);
    step("lu_zero", 0, 0, 0, 1, 0, 0);
    step("lu_rt", 0, 7, 7, 1, 0, 0);
    step("lu_miss", 4, 6, 7, 1, 0, 0);

    // Taken branch: three flush cycles, states 0,2,2,0.
    step("br", 1, 2, 3, 0, 1, 0);
    idle("br_flush", 3);

    // Freeze for four cycles with a branch arriving in the second.
    step("mb1", 1, 2, 3, 0, 0, 1);
    step("mb2", 1, 2, 3, 0, 1, 1);
    step("mb3", 1, 2, 3, 0, 0, 1);
    step("mb4", 1, 2, 3, 0, 0, 1);
    idle("mb_rel", 4);

    // Freeze, branch and load-use together: freeze wins, branch resolves on release.
    step("all3", 5, 5, 5, 1, 1, 1);
    step("all3_rel", 5, 5, 5, 1, 0, 0);
    idle("all3_tail", 3);

    // Freeze in the middle of a flush sequence, then resume it.
    step("fmb_br", 1, 2, 3, 0, 1, 0);
    idle("fmb_f", 1);
    step("fmb_mb", 1, 2, 3, 0, 0, 1);
    step("fmb_mb2", 1, 2, 3, 0, 0, 1);
    idle("fmb_rel", 3);

    // Branch while flushing reloads the count; load-use ignored during flush.
    step("fbr1", 1, 2, 3, 0, 1, 0);
    step("fbr_lu", 4, 4, 4, 1, 0, 0);
    step("fbr2", 1, 2, 3, 0, 1, 0);
    idle("fbr_tail", 3);

    // Reset while flushing with one flush cycle remaining.
    step("rf_br", 1, 2, 3, 0, 1, 0);
    idle("rf_f", 1);
    do_reset("rst_flush");
    idle("rf_after", 3);

    // Long freeze drives the stall counter to saturation.
    for (int i = 0; i < 20; i++) step("sat", 1, 2, 3, 0, 0, 1);
    idle("sat_rel", 4);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 96) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
